prf_alloc_ctrl: RTL and testbench

Allocation controller sitting between the rename/dispatch stage and the physical-register free list. It prefetches free physical registers into a small buffer and hands them to dispatch over a valid/ready handshake. It also forwards committed (retired) old mappings back to the free list, filtering out register 0. It sequences flush recovery and exports an exact count of available physical registers, which dispatch uses for stall decisions.

---
 rtl/prf_alloc_pkg.sv | 15 +
 rtl/prf_prefetch_fifo.sv | 45 ++++
 rtl/prf_alloc_ctrl.sv | 135 +++++++++++++
 tb/tb_prf_alloc_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prf_alloc_pkg.sv
// Shared definitions for the physical-register allocation controller:
// default widths/capacities and the controller state encoding.
package prf_alloc_pkg;

  localparam int PREG_W   = 6;
  localparam int NUM_FREE = 32;
  localparam int PF_DEPTH = 2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    REFILL = 2'd2
  } prf_alloc_state_t;

endpackage

// File: rtl/prf_prefetch_fifo.sv
// Small circular prefetch buffer holding free physical registers ahead of dispatch.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module prf_prefetch_fifo #(
  parameter int DEPTH = prf_alloc_pkg::PF_DEPTH,
  parameter int W     = prf_alloc_pkg::PREG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_occ
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;

  // Clear has priority over any push/pop issued in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  assign o_head = r_mem[r_rd_ptr[AW-1:0]];
  assign o_occ  = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/prf_alloc_ctrl.sv
// Allocation controller between rename/dispatch and the physical-register free list.
// Define PRF_ALLOC_STATS_EN to add the o_alloc_cnt / o_stall_cnt statistics outputs.
module prf_alloc_ctrl #(
  parameter int PREG_W   = prf_alloc_pkg::PREG_W,
  parameter int NUM_FREE = prf_alloc_pkg::NUM_FREE,
  parameter int PF_DEPTH = prf_alloc_pkg::PF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic                      i_alloc_ready,
  output logic                      o_alloc_valid,
  output logic [PREG_W-1:0]         o_alloc_preg,
  input  logic                      i_commit_valid,
  input  logic [PREG_W-1:0]         i_commit_preg,
  output logic [$clog2(NUM_FREE):0] o_free_count,
  output logic                      o_fl_r_en,
  input  logic [PREG_W-1:0]         i_fl_preg,
  input  logic                      i_fl_is_empty,
  output logic                      o_fl_w_en,
  output logic [PREG_W-1:0]         o_fl_freed_reg,
  output logic                      o_fl_flush
`ifdef PRF_ALLOC_STATS_EN
  ,
  output logic [31:0]               o_alloc_cnt,
  output logic [31:0]               o_stall_cnt
`endif
);

  import prf_alloc_pkg::*;

  localparam int CW = $clog2(NUM_FREE) + 1;
  localparam int OW = $clog2(PF_DEPTH) + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(PF_DEPTH);

  prf_alloc_state_t r_state;
  prf_alloc_state_t w_state_next;

  logic [OW-1:0]     w_occ;
  logic [OW-1:0]     w_occ_next;
  logic [PREG_W-1:0] w_head;
  logic              w_pop;
  logic              w_fl_r_en;
  logic              w_commit_take;
  logic [CW-1:0]     r_fl_cnt;
  logic              r_fl_w_en;
  logic [PREG_W-1:0] r_fl_freed_reg;

  prf_prefetch_fifo #(
    .DEPTH (PF_DEPTH),
    .W     (PREG_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (i_flush),
    .i_push      (w_fl_r_en),
    .i_push_data (i_fl_preg),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_occ       (w_occ)
  );

  assign o_alloc_valid = (r_state == RUN) && (w_occ != '0);
  assign w_pop         = o_alloc_valid && i_alloc_ready;
  // Refilling the slot vacated by a same-cycle pop keeps 1 allocation/cycle.
  assign w_fl_r_en     = !rst && !i_fl_is_empty && (r_state != FLUSH) &&
                         ((w_occ < OCC_FULL) || w_pop);
  assign w_occ_next    = w_occ + OW'(w_fl_r_en) - OW'(w_pop);
  assign w_commit_take = i_commit_valid && (i_commit_preg != '0) && !i_flush;

  always_ff @(posedge clk) begin
    if (rst) r_state <= REFILL;
    else     r_state <= w_state_next;
  end

  // REFILL exits on the occupancy after this cycle's fill, saving one bubble.
  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      w_state_next = FLUSH;
    end else begin
      case (r_state)
        FLUSH:   w_state_next = REFILL;
        REFILL:  if ((w_occ_next == OCC_FULL) || (i_fl_is_empty && (w_occ_next != '0)))
                   w_state_next = RUN;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state == FLUSH)) r_fl_cnt <= CW'(NUM_FREE);
    else                           r_fl_cnt <= r_fl_cnt + CW'(r_fl_w_en) - CW'(w_fl_r_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fl_w_en      <= 1'b0;
      r_fl_freed_reg <= '0;
    end else begin
      r_fl_w_en <= w_commit_take;
      if (w_commit_take) r_fl_freed_reg <= i_commit_preg;
    end
  end

  assign o_alloc_preg   = w_head;
  assign o_fl_r_en      = w_fl_r_en;
  assign o_fl_w_en      = r_fl_w_en;
  assign o_fl_freed_reg = r_fl_freed_reg;
  assign o_fl_flush     = (r_state == FLUSH);
  assign o_free_count   = r_fl_cnt + CW'(w_occ);

`ifdef PRF_ALLOC_STATS_EN
  logic [31:0] r_alloc_cnt;
  logic [31:0] r_stall_cnt;

  // Saturating counters, cleared only by reset so they survive flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alloc_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop && (r_alloc_cnt != '1)) r_alloc_cnt <= r_alloc_cnt + 32'd1;
      if (i_alloc_ready && !o_alloc_valid && (r_state == RUN) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_alloc_cnt = r_alloc_cnt;
  assign o_stall_cnt = r_stall_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_prf_alloc_ctrl.sv
// Self-checking bench for prf_alloc_ctrl: startup vector table, drain, commit and
// flush sequences, then random traffic against a queue-based reference model.
module tb_prf_alloc_ctrl;

  localparam int PREG_W   = 6;
  localparam int NUM_FREE = 32;
  localparam int PF_DEPTH = 2;
  localparam int P_RUN    = 0;
  localparam int P_FLUSH  = 1;
  localparam int P_REFILL = 2;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              allocReady;
  logic              allocValid;
  logic [PREG_W-1:0] allocPreg;
  logic              commitValid;
  logic [PREG_W-1:0] commitPreg;
  logic [5:0]        freeCount;
  logic              flREn;
  logic [PREG_W-1:0] flPreg;
  logic              flIsEmpty;
  logic              flWEn;
  logic [PREG_W-1:0] flFreedReg;
  logic              flFlush;
`ifdef PRF_ALLOC_STATS_EN
  logic [31:0]       allocCnt;
  logic [31:0]       stallCnt;
`endif

  prf_alloc_ctrl #(
    .PREG_W   (PREG_W),
    .NUM_FREE (NUM_FREE),
    .PF_DEPTH (PF_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_flush        (flush),
    .i_alloc_ready  (allocReady),
    .o_alloc_valid  (allocValid),
    .o_alloc_preg   (allocPreg),
    .i_commit_valid (commitValid),
    .i_commit_preg  (commitPreg),
    .o_free_count   (freeCount),
    .o_fl_r_en      (flREn),
    .i_fl_preg      (flPreg),
    .i_fl_is_empty  (flIsEmpty),
    .o_fl_w_en      (flWEn),
    .o_fl_freed_reg (flFreedReg),
    .o_fl_flush     (flFlush)
`ifdef PRF_ALLOC_STATS_EN
    ,
    .o_alloc_cnt    (allocCnt),
    .o_stall_cnt    (stallCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: controller phase, prefetch queue, count, pending release,
  // plus the free list itself kept as a ring that feeds the DUT.
  int  mPhase;
  int  mBuf[$];
  int  mFlCnt;
  bit  mWPend;
  int  mWReg;
  int  mFlMem[NUM_FREE];
  int  mFlHead;
  int  mFlTail;
  int  mFlCount;
  int  mAllocs;
  int  mStalls;
  bit  eValid;
  bit  ePop;
  bit  eRdEn;

  typedef struct {
    bit ready;
    bit expValid;
    int expPreg;
    bit expRdEn;
    int expCount;
  } vec_t;

  vec_t startVecs[7];

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit f, input bit r, input bit cv, input int cp);
    flush       = f;
    allocReady  = r;
    commitValid = cv;
    commitPreg  = PREG_W'(cp);
    flIsEmpty   = (mFlCount == 0);
    flPreg      = PREG_W'(mFlMem[mFlHead]);
    #2;
    eValid = (mPhase == P_RUN) && (mBuf.size() > 0);
    ePop   = eValid && r;
    eRdEn  = (mFlCount > 0) && ((mBuf.size() < PF_DEPTH) || ePop) && (mPhase != P_FLUSH);
    checkOutput("alloc_valid", allocValid, eValid);
    if (eValid) checkOutput("alloc_preg", allocPreg, mBuf[0]);
    checkOutput("fl_r_en", flREn, eRdEn);
    checkOutput("free_count", freeCount, mFlCnt + mBuf.size());
    checkOutput("fl_w_en", flWEn, mWPend);
    if (mWPend) checkOutput("fl_freed_reg", flFreedReg, mWReg);
    checkOutput("fl_flush", flFlush, mPhase == P_FLUSH);
  endtask

  task automatic tick();
    bit wasEmpty;
    int got;
    @(posedge clk);
    wasEmpty = (mFlCount == 0);
    got      = 0;
    if (eRdEn) begin
      got      = mFlMem[mFlHead];
      mFlHead  = (mFlHead + 1) % NUM_FREE;
      mFlCount = mFlCount - 1;
    end
    if (mWPend && (mFlCount < NUM_FREE)) begin
      mFlMem[mFlTail] = mWReg;
      mFlTail  = (mFlTail + 1) % NUM_FREE;
      mFlCount = mFlCount + 1;
    end
    if (mPhase == P_FLUSH) begin
      mFlCount = NUM_FREE;
      mFlHead  = mFlTail;
      mFlCnt   = NUM_FREE;
    end else begin
      mFlCnt = mFlCnt + int'(mWPend) - int'(eRdEn);
    end
    if (ePop) mAllocs++;
    if (allocReady && !eValid && (mPhase == P_RUN)) mStalls++;
    if (flush) begin
      mBuf.delete();
      mPhase = P_FLUSH;
      mWPend = 1'b0;
    end else begin
      if (ePop) void'(mBuf.pop_front());
      if (eRdEn) mBuf.push_back(got);
      mWPend = commitValid && (commitPreg != 0);
      if (mWPend) mWReg = int'(commitPreg);
      if (mPhase == P_FLUSH) mPhase = P_REFILL;
      else if ((mPhase == P_REFILL) &&
               ((mBuf.size() == PF_DEPTH) || (wasEmpty && (mBuf.size() != 0))))
        mPhase = P_RUN;
    end
    #1;
  endtask

  initial begin
    bit found;
    bit f;
    bit r;
    bit cv;

    rst = 1'b1; flush = 1'b0; allocReady = 1'b0; commitValid = 1'b0;
    commitPreg = '0; flIsEmpty = 1'b0; flPreg = PREG_W'(32);
    mPhase = P_REFILL; mFlCnt = NUM_FREE; mWPend = 1'b0; mWReg = 0;
    mFlHead = 0; mFlTail = 0; mFlCount = NUM_FREE; mAllocs = 0; mStalls = 0;
    for (int i = 0; i < NUM_FREE; i++) mFlMem[i] = 32 + i;

    startVecs[0] = '{1'b0, 1'b0, -1, 1'b1, 32};
    startVecs[1] = '{1'b0, 1'b0, -1, 1'b1, 32};
    for (int i = 2; i < 7; i++) startVecs[i] = '{1'b0, 1'b1, 32, 1'b0, 32};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_alloc_valid", allocValid, 0);
    checkOutput("rst_alloc_preg", allocPreg, 0);
    checkOutput("rst_fl_r_en", flREn, 0);
    checkOutput("rst_fl_w_en", flWEn, 0);
    checkOutput("rst_fl_freed_reg", flFreedReg, 0);
    checkOutput("rst_fl_flush", flFlush, 0);
    checkOutput("rst_free_count", freeCount, 32);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, startVecs[i].ready, 1'b0, 0);
      checkOutput($sformatf("vec%0d_valid", i), allocValid, startVecs[i].expValid);
      if (startVecs[i].expPreg >= 0)
        checkOutput($sformatf("vec%0d_preg", i), allocPreg, startVecs[i].expPreg);
      checkOutput($sformatf("vec%0d_rden", i), flREn, startVecs[i].expRdEn);
      checkOutput($sformatf("vec%0d_count", i), freeCount, startVecs[i].expCount);
      tick();
    end

    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 0);
      checkOutput("drain_preg", allocPreg, 32 + i);
      checkOutput("drain_count", freeCount, 32 - i);
      checkOutput("drain_rden", flREn, i < 30);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    checkOutput("drained_valid", allocValid, 0);
    checkOutput("drained_count", freeCount, 0);
    checkOutput("drained_rden", flREn, 0);
    tick();

    applyStimulus(1'b0, 1'b0, 1'b1, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    checkOutput("commit0_wen", flWEn, 0);
    tick();

    applyStimulus(1'b0, 1'b1, 1'b1, 45);
    tick();
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 0);
      if (i == 0) begin
        checkOutput("commit45_wen", flWEn, 1);
        checkOutput("commit45_reg", flFreedReg, 45);
        checkOutput("commit45_count0", freeCount, 0);
      end
      if (i == 1) checkOutput("commit45_count1", freeCount, 1);
      if (allocValid && (allocPreg == PREG_W'(45))) found = 1'b1;
      tick();
    end
    checkOutput("commit45_alloc", found, 1);

    applyStimulus(1'b1, 1'b0, 1'b1, 50);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    checkOutput("flush_pulse", flFlush, 1);
    checkOutput("flush_drop_wen", flWEn, 0);
    checkOutput("flush_valid0", allocValid, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    checkOutput("refill1_flush", flFlush, 0);
    checkOutput("refill1_valid0", allocValid, 0);
    checkOutput("refill1_count", freeCount, 32);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    checkOutput("refill2_valid0", allocValid, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    checkOutput("refill_done_valid", allocValid, 1);
    tick();

    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    checkOutput("dflush_a", flFlush, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    checkOutput("dflush_b", flFlush, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    checkOutput("dflush_end", flFlush, 0);
    tick();

    for (int n = 0; n < 800; n++) begin
      f  = ($urandom_range(0, 39) == 0);
      r  = ($urandom_range(0, 3) != 0);
      cv = ($urandom_range(0, 1) == 1) && (mPhase != P_FLUSH) &&
           ((mFlCount + int'(mWPend)) < NUM_FREE);
      applyStimulus(f, r, cv, int'($urandom_range(0, 63)));
      tick();
    end

`ifdef PRF_ALLOC_STATS_EN
    checkOutput("alloc_cnt", allocCnt, mAllocs);
    checkOutput("stall_cnt", stallCnt, mStalls);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
